atm_controller_multi: RTL and testbench
=======================================

Name: atm_controller_multi

Overview:
Second-generation ATM session controller. It handles card insertion, parametrised PIN entry with attempt counting, and deposit/withdrawal against an internal balance. New over the first generation: a daily withdrawal limit with day rollover, an inactivity timeout, card-removal abort, and a visible balance output. It sits between the keypad/card front end and the cash dispenser, and is driven by the same style of stimulus tester.

Parameters:
PIN_DIGITS, 4, number of 4-bit digits in the PIN.
PIN_VALUE, 16'h1234, correct PIN, width 4*PIN_DIGITS, first digit entered in the MS nibble.
MAX_TRIES, 3, wrong-PIN attempts before block (>=2).
AMT_W, 32, width of monto.
BAL_W, 40, width of balance and of the daily accumulator.
INIT_BALANCE, 1000, balance after reset.
DAILY_LIMIT, 500, maximum total withdrawn per day.
TIMEOUT_CYCLES, 1000, idle cycles before session abort; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
tarjeta_recibida  in  1  level, card present.
tipo_trans  in  1  0 = deposit, 1 = withdrawal; sampled with monto_stb.
add_digit  in  1  one-cycle strobe, digito valid.
digito  in  4  PIN digit.
monto_stb  in  1  one-cycle strobe, monto valid.
monto  in  AMT_W  transaction amount.
dia_nuevo  in  1  one-cycle day-rollover strobe.
balance_actualizado  out  1  pulse.
entregar_dinero  out  1  pulse.
pin_incorrecto  out  1  pulse.
advertencia  out  1  level.
bloqueo  out  1  level, sticky.
fondos_insuficientes  out  1  pulse.
limite_excedido  out  1  pulse.
tiempo_agotado  out  1  pulse.
balance  out  BAL_W  current balance (registered).

Behaviour:
- Reset (async): state IDLE; balance = INIT_BALANCE; tries = 0; daily accumulator = 0; all 1-bit outputs 0.
- All outputs are registered. "Pulse" means high for exactly one cycle.
- States: IDLE, PIN_ENTRY, CHECK_PIN, WAIT_AMOUNT, PROCESS, BLOCKED.
- IDLE: tarjeta_recibida=1 -> PIN_ENTRY; clear digit count, PIN shift register and timer.
- PIN_ENTRY:
  - Each add_digit shifts digito into the LS nibble.
  - Digits >9 are accepted and cause a mismatch.
  - When the PIN_DIGITS-th digit is taken -> CHECK_PIN.
- CHECK_PIN (one cycle):
  - Match: tries = 0 -> WAIT_AMOUNT.
  - Mismatch: tries+1 and pin_incorrecto pulse. If the new tries = MAX_TRIES -> BLOCKED, else -> PIN_ENTRY with the digit count cleared.
- advertencia = (tries == MAX_TRIES-1). tries persists across sessions, timeouts and card removal; it clears only on a correct PIN or rst.
- BLOCKED: bloqueo=1, all inputs ignored; exit only via rst. advertencia is 0 here.
- WAIT_AMOUNT: monto_stb latches monto (zero-extended to BAL_W) and tipo_trans -> PROCESS.
- PROCESS (one cycle), then -> IDLE:
  - Deposit: balance += monto, saturating at 2^BAL_W-1; balance_actualizado pulse.
  - Withdrawal, checked in priority order:
    1. monto > balance -> fondos_insuficientes.
    2. Else acc + monto > DAILY_LIMIT -> limite_excedido.
    3. Else balance -= monto, acc += monto, balance_actualizado and entregar_dinero pulse together.
  - monto = 0 is legal and yields an update pulse with no change.
- Latency: monto_stb sampled at edge k -> result pulses high from edge k+2 to k+3; balance output updates at edge k+2.
- dia_nuevo clears acc in any state. If it coincides with a PROCESS withdrawal, the limit check uses acc = 0 and acc becomes monto.
- Timeout: in PIN_ENTRY and WAIT_AMOUNT a timer counts cycles without add_digit/monto_stb and restarts on each strobe. Reaching TIMEOUT_CYCLES -> tiempo_agotado pulse -> IDLE; the partial PIN is discarded.
- tarjeta_recibida=0 in PIN_ENTRY, CHECK_PIN or WAIT_AMOUNT -> IDLE with no pulses. CHECK_PIN still commits a mismatch count in that cycle. PROCESS always completes.
- add_digit outside PIN_ENTRY and monto_stb outside WAIT_AMOUNT are ignored.
- Re-entry: from IDLE a still-present card starts a new session on the next cycle.

Decomposition:
- Package atm_pkg: state enum, TIPO_DEPOSITO=0 / TIPO_RETIRO=1 constants.
- One sub-module, atm_timeout: parametrised idle counter with restart, enable and expiry-pulse ports.

Test Plan (defaults, TIMEOUT_CYCLES=20):
- Card, digits 1,2,3,4, withdraw 300 -> entregar_dinero and balance_actualizado pulse 2 cycles after monto_stb; balance = 700.
- Second session withdraw 300 -> limite_excedido, balance stays 700. Pulse dia_nuevo, retry 300 -> success, balance = 400.
- PIN 1,2,3,5 twice -> two pin_incorrecto pulses; advertencia=1 after the second. Correct PIN -> advertencia=0. Reload balance by deposit.
- Wrong PIN three times -> bloqueo=1 sticky; correct PIN afterwards has no effect; rst -> bloqueo=0, balance=1000.
- Withdraw 2000 with balance 1000 -> fondos_insuficientes only; deposit 250 -> balance = 1250.
- Enter 2 digits, then idle 20 cycles -> tiempo_agotado pulse, state IDLE. Separately, remove the card in WAIT_AMOUNT -> IDLE, no pulses. Assert rst mid-PIN -> all outputs 0 immediately.

Source files
------------

// File: rtl/atm_controller_multi_pkg.sv
// Shared types and constants for the ATM session controller.
package atm_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PIN_ENTRY,
      S_CHECK_PIN,
      S_WAIT_AMOUNT,
      S_PROCESS,
      S_BLOCKED
   } state_e;

   localparam logic TIPO_DEPOSITO = 1'b0;
   localparam logic TIPO_RETIRO   = 1'b1;

endpackage

// File: rtl/atm_controller_multi_timeout.sv
// Idle-cycle counter: flags expiry after CYCLES enabled cycles without a restart.
module atm_timeout #(
   parameter int unsigned CYCLES = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic restart,
   output logic expired
);

   localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [CW-1:0] count;

   // CYCLES == 0 disables expiry entirely.
   always_comb begin
      expired = (CYCLES != 0) && enable && !restart && (count == CW'(CYCLES - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (!enable || restart || expired) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/atm_controller_multi.sv
// ATM session controller: card/PIN sessions, deposit/withdrawal with a daily
// limit, inactivity timeout and sticky lockout after repeated wrong PINs.
module atm_controller_multi
   import atm_pkg::*;
#(
   parameter int unsigned              PIN_DIGITS     = 4,
   parameter logic [4*PIN_DIGITS-1:0]  PIN_VALUE      = 16'h1234,
   parameter int unsigned              MAX_TRIES      = 3,
   parameter int unsigned              AMT_W          = 32,
   parameter int unsigned              BAL_W          = 40,
   parameter logic [BAL_W-1:0]         INIT_BALANCE   = BAL_W'(1000),
   parameter logic [BAL_W-1:0]         DAILY_LIMIT    = BAL_W'(500),
   parameter int unsigned              TIMEOUT_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tarjeta_recibida,
   input  logic             tipo_trans,
   input  logic             add_digit,
   input  logic [3:0]       digito,
   input  logic             monto_stb,
   input  logic [AMT_W-1:0] monto,
   input  logic             dia_nuevo,
   output logic             balance_actualizado,
   output logic             entregar_dinero,
   output logic             pin_incorrecto,
   output logic             advertencia,
   output logic             bloqueo,
   output logic             fondos_insuficientes,
   output logic             limite_excedido,
   output logic             tiempo_agotado,
   output logic [BAL_W-1:0] balance
);

   localparam int unsigned PW = 4 * PIN_DIGITS;
   localparam int unsigned DW = $clog2(PIN_DIGITS + 1);
   localparam int unsigned TW = $clog2(MAX_TRIES + 1);

   state_e           state, state_n;
   logic [DW-1:0]    dcnt, dcnt_n;
   logic [PW-1:0]    pin_sr, pin_sr_n;
   logic [TW-1:0]    tries, tries_n;
   logic [BAL_W-1:0] acc, acc_n, acc_eff;
   logic [BAL_W-1:0] bal_int, bal_int_n;
   logic [BAL_W-1:0] amt_q, amt_n;
   logic             tipo_q, tipo_n;
   logic [BAL_W:0]   sum_dep, sum_acc;

   logic upd_r, ent_r, nsf_r, lim_r;
   logic upd_n, ent_n, nsf_n, lim_n;
   logic pin_bad_n, to_n, adv_n;

   logic tmr_en, tmr_restart, tmr_expired;

   always_comb begin
      tmr_en      = (state == S_PIN_ENTRY) || (state == S_WAIT_AMOUNT);
      tmr_restart = ((state == S_PIN_ENTRY) && add_digit) ||
                    ((state == S_WAIT_AMOUNT) && monto_stb);
   end

   atm_timeout #(
      .CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .enable  (tmr_en),
      .restart (tmr_restart),
      .expired (tmr_expired)
   );

   always_comb begin
      state_n   = state;
      dcnt_n    = dcnt;
      pin_sr_n  = pin_sr;
      tries_n   = tries;
      acc_eff   = dia_nuevo ? '0 : acc;
      acc_n     = acc_eff;
      bal_int_n = bal_int;
      amt_n     = amt_q;
      tipo_n    = tipo_q;
      upd_n     = 1'b0;
      ent_n     = 1'b0;
      nsf_n     = 1'b0;
      lim_n     = 1'b0;
      pin_bad_n = 1'b0;
      to_n      = 1'b0;
      sum_dep   = {1'b0, bal_int} + {1'b0, amt_q};
      sum_acc   = {1'b0, acc_eff} + {1'b0, amt_q};

      unique case (state)
         S_IDLE: begin
            if (tarjeta_recibida) begin
               state_n  = S_PIN_ENTRY;
               dcnt_n   = '0;
               pin_sr_n = '0;
            end
         end

         S_PIN_ENTRY: begin
            if (!tarjeta_recibida) begin
               state_n = S_IDLE;
            end else if (add_digit) begin
               pin_sr_n = (pin_sr << 4) | PW'(digito);
               dcnt_n   = dcnt + 1'b1;
               if (dcnt == DW'(PIN_DIGITS - 1)) begin
                  state_n = S_CHECK_PIN;
               end
            end else if (tmr_expired) begin
               to_n    = 1'b1;
               state_n = S_IDLE;
            end
         end

         // A mismatch is committed even if the card left this cycle; reaching
         // the limit still locks out, otherwise removal only suppresses the pulse.
         S_CHECK_PIN: begin
            if (pin_sr == PIN_VALUE) begin
               tries_n = '0;
               state_n = tarjeta_recibida ? S_WAIT_AMOUNT : S_IDLE;
            end else begin
               tries_n   = tries + 1'b1;
               pin_bad_n = tarjeta_recibida;
               if (tries_n == TW'(MAX_TRIES)) begin
                  state_n = S_BLOCKED;
               end else if (!tarjeta_recibida) begin
                  state_n = S_IDLE;
               end else begin
                  state_n = S_PIN_ENTRY;
                  dcnt_n  = '0;
               end
            end
         end

         S_WAIT_AMOUNT: begin
            if (!tarjeta_recibida) begin
               state_n = S_IDLE;
            end else if (monto_stb) begin
               amt_n   = BAL_W'(monto);
               tipo_n  = tipo_trans;
               state_n = S_PROCESS;
            end else if (tmr_expired) begin
               to_n    = 1'b1;
               state_n = S_IDLE;
            end
         end

         S_PROCESS: begin
            state_n = S_IDLE;
            if (tipo_q == TIPO_DEPOSITO) begin
               bal_int_n = sum_dep[BAL_W] ? '1 : sum_dep[BAL_W-1:0];
               upd_n     = 1'b1;
            end else if (amt_q > bal_int) begin
               nsf_n = 1'b1;
            end else if (sum_acc > {1'b0, DAILY_LIMIT}) begin
               lim_n = 1'b1;
            end else begin
               bal_int_n = bal_int - amt_q;
               acc_n     = sum_acc[BAL_W-1:0];
               upd_n     = 1'b1;
               ent_n     = 1'b1;
            end
         end

         S_BLOCKED: begin
            state_n = S_BLOCKED;
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase

      adv_n = (state_n != S_BLOCKED) && (tries_n == TW'(MAX_TRIES - 1));
   end

   // Transaction results pass through one extra register stage so the pulses
   // and the visible balance land two edges after monto_stb is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                <= S_IDLE;
         dcnt                 <= '0;
         pin_sr               <= '0;
         tries                <= '0;
         acc                  <= '0;
         bal_int              <= INIT_BALANCE;
         amt_q                <= '0;
         tipo_q               <= 1'b0;
         upd_r                <= 1'b0;
         ent_r                <= 1'b0;
         nsf_r                <= 1'b0;
         lim_r                <= 1'b0;
         balance_actualizado  <= 1'b0;
         entregar_dinero      <= 1'b0;
         fondos_insuficientes <= 1'b0;
         limite_excedido      <= 1'b0;
         pin_incorrecto       <= 1'b0;
         tiempo_agotado       <= 1'b0;
         advertencia          <= 1'b0;
         bloqueo              <= 1'b0;
         balance              <= INIT_BALANCE;
      end else begin
         state                <= state_n;
         dcnt                 <= dcnt_n;
         pin_sr               <= pin_sr_n;
         tries                <= tries_n;
         acc                  <= acc_n;
         bal_int              <= bal_int_n;
         amt_q                <= amt_n;
         tipo_q               <= tipo_n;
         upd_r                <= upd_n;
         ent_r                <= ent_n;
         nsf_r                <= nsf_n;
         lim_r                <= lim_n;
         balance_actualizado  <= upd_r;
         entregar_dinero      <= ent_r;
         fondos_insuficientes <= nsf_r;
         limite_excedido      <= lim_r;
         pin_incorrecto       <= pin_bad_n;
         tiempo_agotado       <= to_n;
         advertencia          <= adv_n;
         bloqueo              <= (state_n == S_BLOCKED);
         balance              <= bal_int;
      end
   end

endmodule

// File: tb/tb_atm_controller_multi.sv
// Self-checking bench for atm_controller_multi: directed session table, corner
// sequences, then randomized sessions against a session-level account model.
module tb_atm_controller_multi;

   localparam int unsigned AMT_W = 32;
   localparam int unsigned BAL_W = 40;
   localparam logic [15:0] PIN_OK = 16'h1234;
   localparam logic [3:0]  P_NONE = 4'b0000;
   localparam logic [3:0]  P_OKW  = 4'b1100;
   localparam logic [3:0]  P_OKD  = 4'b1000;
   localparam logic [3:0]  P_NSF  = 4'b0010;
   localparam logic [3:0]  P_LIM  = 4'b0001;
   localparam logic [63:0] MAXB   = 64'h00FF_FFFF_FFFF;

   logic             clk = 1'b0;
   logic             rst;
   logic             tarjeta_recibida, tipo_trans, add_digit, monto_stb, dia_nuevo;
   logic [3:0]       digito;
   logic [AMT_W-1:0] monto;
   logic             balance_actualizado, entregar_dinero, pin_incorrecto, advertencia;
   logic             bloqueo, fondos_insuficientes, limite_excedido, tiempo_agotado;
   logic [BAL_W-1:0] balance;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   atm_controller_multi #(
      .TIMEOUT_CYCLES(20)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .tarjeta_recibida     (tarjeta_recibida),
      .tipo_trans           (tipo_trans),
      .add_digit            (add_digit),
      .digito               (digito),
      .monto_stb            (monto_stb),
      .monto                (monto),
      .dia_nuevo            (dia_nuevo),
      .balance_actualizado  (balance_actualizado),
      .entregar_dinero      (entregar_dinero),
      .pin_incorrecto       (pin_incorrecto),
      .advertencia          (advertencia),
      .bloqueo              (bloqueo),
      .fondos_insuficientes (fondos_insuficientes),
      .limite_excedido      (limite_excedido),
      .tiempo_agotado       (tiempo_agotado),
      .balance              (balance)
   );

   typedef struct {
      logic [15:0]      pin;
      logic             tipo;
      logic [31:0]      amt;
      logic             dia_before;
      logic             dia_proc;
      logic [3:0]       exp_v;
      logic [BAL_W-1:0] exp_bal;
      logic             exp_adv;
   } vec_t;

   vec_t tbl[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] pv();
      return {balance_actualizado, entregar_dinero, fondos_insuficientes, limite_excedido};
   endfunction

   function automatic logic [7:0] all_flags();
      return {pv(), pin_incorrecto, tiempo_agotado, advertencia, bloqueo};
   endfunction

   task automatic open_session(input logic dia_before);
      tarjeta_recibida = 1'b0;
      cyc();
      if (dia_before) begin
         dia_nuevo = 1'b1;
         cyc();
         dia_nuevo = 1'b0;
      end
      tarjeta_recibida = 1'b1;
      cyc();
   endtask

   task automatic enter_digits(input logic [15:0] pin, input int n);
      for (int i = 0; i < n; i++) begin
         add_digit = 1'b1;
         digito    = pin[15-4*i -: 4];
         cyc();
      end
      add_digit = 1'b0;
   endtask

   task automatic enter_pin(input logic [15:0] pin, output logic bad, output logic adv);
      enter_digits(pin, 4);
      cyc();
      bad = pin_incorrecto;
      adv = advertencia;
   endtask

   task automatic do_amount(input logic tipo, input logic [31:0] amt, input logic dia_proc,
                            output logic [3:0] v1, output logic [3:0] v2, output logic [3:0] v3,
                            output logic [BAL_W-1:0] b2);
      monto_stb  = 1'b1;
      tipo_trans = tipo;
      monto      = amt;
      cyc();
      monto_stb        = 1'b0;
      tarjeta_recibida = 1'b0;
      dia_nuevo        = dia_proc;
      cyc();
      dia_nuevo = 1'b0;
      v1 = pv();
      cyc();
      v2 = pv();
      b2 = balance;
      cyc();
      v3 = pv();
   endtask

   task automatic run_session(input vec_t v, input string tag);
      logic bad, adv;
      logic [3:0] v1, v2, v3;
      logic [BAL_W-1:0] b2;
      open_session(v.dia_before);
      enter_pin(v.pin, bad, adv);
      check({tag, "_pinbad"}, 64'(bad), 64'(v.pin != PIN_OK));
      check({tag, "_adv"}, 64'(adv), 64'(v.exp_adv));
      check({tag, "_bloqueo"}, 64'(bloqueo), 64'd0);
      if (v.pin == PIN_OK) begin
         do_amount(v.tipo, v.amt, v.dia_proc, v1, v2, v3, b2);
         check({tag, "_early"}, 64'(v1), 64'(P_NONE));
         check({tag, "_pulse"}, 64'(v2), 64'(v.exp_v));
         check({tag, "_late"}, 64'(v3), 64'(P_NONE));
         check({tag, "_bal"}, 64'(b2), 64'(v.exp_bal));
      end else begin
         tarjeta_recibida = 1'b0;
         cyc();
      end
   endtask

   task automatic do_reset();
      tarjeta_recibida = 1'b0;
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   initial begin : main
      logic bad, adv;
      logic [3:0] v1, v2, v3;
      logic [BAL_W-1:0] b2;
      logic [63:0] m_bal, m_acc;
      int m_tries;
      vec_t rv;
      int dia_mode;
      logic [7:0] seen;

      //           pin     tipo  amt   dia_b dia_p exp_v  exp_bal adv
      tbl[0]  = '{PIN_OK,  1'b1, 300,  1'b0, 1'b0, P_OKW, 700,    1'b0};
      tbl[1]  = '{PIN_OK,  1'b1, 300,  1'b0, 1'b0, P_LIM, 700,    1'b0};
      tbl[2]  = '{PIN_OK,  1'b1, 300,  1'b1, 1'b0, P_OKW, 400,    1'b0};
      tbl[3]  = '{16'h1235,1'b0, 0,    1'b0, 1'b0, P_NONE,400,    1'b0};
      tbl[4]  = '{16'h1235,1'b0, 0,    1'b0, 1'b0, P_NONE,400,    1'b1};
      tbl[5]  = '{PIN_OK,  1'b0, 600,  1'b0, 1'b0, P_OKD, 1000,   1'b0};
      tbl[6]  = '{PIN_OK,  1'b1, 2000, 1'b0, 1'b0, P_NSF, 1000,   1'b0};
      tbl[7]  = '{PIN_OK,  1'b0, 250,  1'b0, 1'b0, P_OKD, 1250,   1'b0};
      tbl[8]  = '{PIN_OK,  1'b1, 0,    1'b0, 1'b0, P_OKW, 1250,   1'b0};
      tbl[9]  = '{PIN_OK,  1'b1, 200,  1'b0, 1'b0, P_OKW, 1050,   1'b0};
      tbl[10] = '{PIN_OK,  1'b1, 1,    1'b0, 1'b0, P_LIM, 1050,   1'b0};
      tbl[11] = '{PIN_OK,  1'b1, 500,  1'b0, 1'b1, P_OKW, 550,    1'b0};

      rst = 1'b1;
      tarjeta_recibida = 1'b0;
      tipo_trans = 1'b0;
      add_digit = 1'b0;
      digito = '0;
      monto_stb = 1'b0;
      monto = '0;
      dia_nuevo = 1'b0;
      cyc();
      check("reset_flags", 64'(all_flags()), 64'd0);
      check("reset_balance", 64'(balance), 64'd1000);
      cyc();
      rst = 1'b0;
      cyc();

      for (int i = 0; i < 12; i++) begin
         run_session(tbl[i], $sformatf("tbl%0d", i));
      end

      // Lockout: three wrong PINs, then a correct one is ignored until rst.
      open_session(1'b0);
      for (int i = 0; i < 3; i++) begin
         enter_pin(16'h1235, bad, adv);
         check($sformatf("blk%0d_pinbad", i), 64'(bad), 64'd1);
         check($sformatf("blk%0d_adv", i), 64'(adv), 64'(i == 1));
      end
      check("blk_bloqueo", 64'(bloqueo), 64'd1);
      enter_pin(PIN_OK, bad, adv);
      check("blk_ok_pinbad", 64'(bad), 64'd0);
      tarjeta_recibida = 1'b1;
      do_amount(1'b0, 100, 1'b0, v1, v2, v3, b2);
      check("blk_no_pulse", 64'({v1, v2, v3}), 64'd0);
      check("blk_bal", 64'(b2), 64'd550);
      check("blk_sticky", 64'(bloqueo), 64'd1);
      rst = 1'b1;
      #1;
      check("blk_rst_bloqueo", 64'(bloqueo), 64'd0);
      check("blk_rst_balance", 64'(balance), 64'd1000);
      cyc();
      rst = 1'b0;
      cyc();

      // Timeout after two digits: pulse on the 20th idle cycle, PIN discarded.
      open_session(1'b0);
      enter_digits(16'h1200, 2);
      repeat (19) cyc();
      check("to_before", 64'(tiempo_agotado), 64'd0);
      cyc();
      check("to_pulse", 64'(tiempo_agotado), 64'd1);
      cyc();
      check("to_after", 64'(tiempo_agotado), 64'd0);
      enter_pin(PIN_OK, bad, adv);
      check("to_fresh_pin", 64'(bad), 64'd0);
      tarjeta_recibida = 1'b1;
      do_amount(1'b0, 0, 1'b0, v1, v2, v3, b2);
      check("to_dep0_pulse", 64'(v2), 64'(P_OKD));
      check("to_dep0_bal", 64'(b2), 64'd1000);

      // Card removed while waiting for an amount: no transaction.
      open_session(1'b0);
      enter_pin(PIN_OK, bad, adv);
      tarjeta_recibida = 1'b0;
      cyc();
      monto_stb = 1'b1;
      tipo_trans = 1'b0;
      monto = 100;
      cyc();
      monto_stb = 1'b0;
      seen = '0;
      for (int i = 0; i < 4; i++) begin
         seen = seen | all_flags();
         cyc();
      end
      check("rm_no_pulse", 64'(seen), 64'd0);
      check("rm_bal", 64'(balance), 64'd1000);

      // Async reset mid-PIN clears outputs immediately and the try counter.
      open_session(1'b0);
      enter_pin(16'h1235, bad, adv);
      enter_pin(16'h1235, bad, adv);
      check("mid_adv_set", 64'(advertencia), 64'd1);
      enter_digits(16'h1200, 2);
      #3;
      rst = 1'b1;
      #1;
      check("mid_rst_flags", 64'(all_flags()), 64'd0);
      check("mid_rst_bal", 64'(balance), 64'd1000);
      cyc();
      rst = 1'b0;
      cyc();
      open_session(1'b0);
      enter_pin(16'h1235, bad, adv);
      check("mid_tries_cleared", 64'(adv), 64'd0);

      // Randomized sessions against an account-level model.
      do_reset();
      m_bal = 1000;
      m_acc = 0;
      m_tries = 0;
      for (int n = 0; n < 60; n++) begin
         dia_mode = int'($urandom_range(0, 4));
         rv.dia_before = (dia_mode == 0);
         rv.dia_proc   = (dia_mode == 1);
         rv.tipo       = 1'($urandom_range(0, 1));
         rv.amt        = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5000) : $urandom_range(0, 600);
         if (m_tries == 2 || $urandom_range(0, 3) != 0) begin
            rv.pin = PIN_OK;
         end else begin
            rv.pin = 16'($urandom_range(0, 65535));
            if (rv.pin == PIN_OK) rv.pin = 16'h1235;
         end
         if (rv.dia_before) m_acc = 0;
         rv.exp_v = P_NONE;
         if (rv.pin != PIN_OK) begin
            m_tries++;
         end else begin
            m_tries = 0;
            if (rv.dia_proc) m_acc = 0;
            if (rv.tipo == 1'b0) begin
               rv.exp_v = P_OKD;
               m_bal = (m_bal + rv.amt > MAXB) ? MAXB : m_bal + rv.amt;
            end else if (rv.amt > m_bal) begin
               rv.exp_v = P_NSF;
            end else if (m_acc + rv.amt > 500) begin
               rv.exp_v = P_LIM;
            end else begin
               rv.exp_v = P_OKW;
               m_bal = m_bal - rv.amt;
               m_acc = m_acc + rv.amt;
            end
         end
         rv.exp_adv = (m_tries == 2);
         rv.exp_bal = BAL_W'(m_bal);
         run_session(rv, $sformatf("rnd%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
